// File: rtl/uart_rx_cmd_decoder.sv
// Assembles UART byte streams into register-file and ALU command frames.
// Complete frames commit outputs and pulse one strobe; bad bytes abort the frame and pulse cmd_err.
module uart_rx_cmd_decoder #(
    parameter int ADDR_W = 4,
    parameter int FUN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_err,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [7:0]        rf_wdata,
    output logic              alu_en,
    output logic [FUN_W-1:0]  alu_fun,
    output logic [7:0]        op_a,
    output logic [7:0]        op_b,
    output logic              busy,
    output logic              cmd_err
);

    localparam logic [7:0] OPC_WR     = 8'hAA;
    localparam logic [7:0] OPC_RD     = 8'hBB;
    localparam logic [7:0] OPC_ALU    = 8'hCC;
    localparam logic [7:0] OPC_ALU_NO = 8'hDD;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        ALU_A,
        ALU_B,
        ALU_FUN
    } state_t;

    state_t state;
    state_t state_next;

    // Shadow registers hold partial-frame bytes until the frame completes.
    logic [ADDR_W-1:0] addr_sh;
    logic [7:0]        a_sh;
    logic [7:0]        b_sh;
    logic              with_ops;

    logic byte_ok;
    logic byte_bad;
    logic do_wr;
    logic do_rd;
    logic do_alu;
    logic do_err;
    logic ld_addr;
    logic ld_a;
    logic ld_b;
    logic set_ops;
    logic ops_val;
    logic clr_sh;

    assign byte_ok  = rx_valid & ~rx_err;
    assign byte_bad = rx_valid & rx_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_wr      = 1'b0;
        do_rd      = 1'b0;
        do_alu     = 1'b0;
        do_err     = 1'b0;
        ld_addr    = 1'b0;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        set_ops    = 1'b0;
        ops_val    = 1'b0;
        clr_sh     = 1'b0;
        if (byte_bad) begin
            state_next = IDLE;
            do_err     = 1'b1;
            clr_sh     = 1'b1;
        end else if (byte_ok) begin
            case (state)
                IDLE: begin
                    case (rx_data)
                        OPC_WR:  state_next = WR_ADDR;
                        OPC_RD:  state_next = RD_ADDR;
                        OPC_ALU: begin
                            state_next = ALU_A;
                            set_ops    = 1'b1;
                            ops_val    = 1'b1;
                        end
                        OPC_ALU_NO: begin
                            state_next = ALU_FUN;
                            set_ops    = 1'b1;
                            ops_val    = 1'b0;
                        end
                        default: do_err = 1'b1;
                    endcase
                end
                WR_ADDR: begin
                    ld_addr    = 1'b1;
                    state_next = WR_DATA;
                end
                WR_DATA: begin
                    do_wr      = 1'b1;
                    clr_sh     = 1'b1;
                    state_next = IDLE;
                end
                RD_ADDR: begin
                    do_rd      = 1'b1;
                    clr_sh     = 1'b1;
                    state_next = IDLE;
                end
                ALU_A: begin
                    ld_a       = 1'b1;
                    state_next = ALU_B;
                end
                ALU_B: begin
                    ld_b       = 1'b1;
                    state_next = ALU_FUN;
                end
                ALU_FUN: begin
                    do_alu     = 1'b1;
                    clr_sh     = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_sh  <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            with_ops <= 1'b0;
        end else if (clr_sh) begin
            addr_sh  <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            with_ops <= 1'b0;
        end else begin
            if (ld_addr) addr_sh  <= rx_data[ADDR_W-1:0];
            if (ld_a)    a_sh     <= rx_data;
            if (ld_b)    b_sh     <= rx_data;
            if (set_ops) with_ops <= ops_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en <= 1'b0;
            rf_rd_en <= 1'b0;
            alu_en   <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            rf_wr_en <= do_wr;
            rf_rd_en <= do_rd;
            alu_en   <= do_alu;
            cmd_err  <= do_err;
        end
    end

    // Held outputs change only when a frame completes; aborts leave them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_addr  <= '0;
            rf_wdata <= '0;
            alu_fun  <= '0;
            op_a     <= '0;
            op_b     <= '0;
        end else begin
            if (do_wr) begin
                rf_addr  <= addr_sh;
                rf_wdata <= rx_data;
            end
            if (do_rd) begin
                rf_addr <= rx_data[ADDR_W-1:0];
            end
            if (do_alu) begin
                alu_fun <= rx_data[FUN_W-1:0];
                if (with_ops) begin
                    op_a <= a_sh;
                    op_b <= b_sh;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cmd_decoder.sv
// Frame-level reference model compared against the decoder every cycle,
// plus directed frames with hand-computed expected values.
module tb_uart_rx_cmd_decoder;

    localparam int ADDR_W = 4;
    localparam int FUN_W  = 4;

    logic              clk;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_err;
    logic              rf_wr_en;
    logic              rf_rd_en;
    logic [ADDR_W-1:0] rf_addr;
    logic [7:0]        rf_wdata;
    logic              alu_en;
    logic [FUN_W-1:0]  alu_fun;
    logic [7:0]        op_a;
    logic [7:0]        op_b;
    logic              busy;
    logic              cmd_err;

    uart_rx_cmd_decoder #(.ADDR_W(ADDR_W), .FUN_W(FUN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .rf_wr_en (rf_wr_en),
        .rf_rd_en (rf_rd_en),
        .rf_addr  (rf_addr),
        .rf_wdata (rf_wdata),
        .alu_en   (alu_en),
        .alu_fun  (alu_fun),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // model state: bytes of the frame received so far, plus expected outputs
    logic [7:0]        frame_q[$];
    logic              e_wr, e_rd, e_alu, e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_wdata, e_a, e_b;
    logic [FUN_W-1:0]  e_fun;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int frame_len(input logic [7:0] opc);
        case (opc)
            8'hAA:   return 3;
            8'hBB:   return 2;
            8'hCC:   return 4;
            8'hDD:   return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_update(input logic r, input logic v, input logic [7:0] d, input logic e);
        logic [7:0] b1, b2, b3;
        e_wr  = 1'b0;
        e_rd  = 1'b0;
        e_alu = 1'b0;
        e_err = 1'b0;
        if (r) begin
            frame_q.delete();
            e_addr = '0; e_wdata = '0; e_a = '0; e_b = '0; e_fun = '0;
        end else if (v) begin
            if (e) begin
                e_err = 1'b1;
                frame_q.delete();
            end else if (frame_q.size() == 0 && frame_len(d) == 0) begin
                e_err = 1'b1;
            end else begin
                frame_q.push_back(d);
                if (frame_q.size() == frame_len(frame_q[0])) begin
                    b1 = frame_q[1];
                    b2 = (frame_q.size() > 2) ? frame_q[2] : 8'h00;
                    b3 = (frame_q.size() > 3) ? frame_q[3] : 8'h00;
                    case (frame_q[0])
                        8'hAA: begin e_wr = 1'b1; e_addr = b1[ADDR_W-1:0]; e_wdata = b2; end
                        8'hBB: begin e_rd = 1'b1; e_addr = b1[ADDR_W-1:0]; end
                        8'hCC: begin e_alu = 1'b1; e_a = b1; e_b = b2; e_fun = b3[FUN_W-1:0]; end
                        default: begin e_alu = 1'b1; e_fun = b1[FUN_W-1:0]; end
                    endcase
                    frame_q.delete();
                end
            end
        end
    endtask

    // driver: present one cycle of input, update the model at the edge, return at negedge
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic e);
        rst      = r;
        rx_valid = v;
        rx_data  = d;
        rx_err   = e;
        @(posedge clk);
        model_update(r, v, d, e);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // scoreboard compare, every cycle once reset has been applied
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rf_wr_en", rf_wr_en, e_wr);
            chk("rf_rd_en", rf_rd_en, e_rd);
            chk("alu_en",   alu_en,   e_alu);
            chk("cmd_err",  cmd_err,  e_err);
            chk("rf_addr",  rf_addr,  e_addr);
            chk("rf_wdata", rf_wdata, e_wdata);
            chk("alu_fun",  alu_fun,  e_fun);
            chk("op_a",     op_a,     e_a);
            chk("op_b",     op_b,     e_b);
            chk("busy",     busy,     frame_q.size() != 0);
            chk("onehot",   32'(rf_wr_en) + 32'(rf_rd_en) + 32'(alu_en) + 32'(cmd_err) <= 1, 1);
        end
    end

    initial begin
        logic [7:0] rb;
        int         sel;
        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_err = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        cmp_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_strb", {rf_wr_en, rf_rd_en, alu_en, cmd_err}, 0);

        // write frame
        send(8'hAA); send(8'h05); send(8'h3C);
        chk("wr_en", rf_wr_en, 1);
        chk("wr_addr", rf_addr, 5);
        chk("wr_data", rf_wdata, 8'h3C);
        chk("wr_busy", busy, 0);
        idle();
        chk("wr_pulse", rf_wr_en, 0);

        // read frame with a gap
        send(8'hBB);
        for (int i = 0; i < 20; i++) begin
            idle();
            chk("rd_gap_busy", busy, 1);
        end
        send(8'h0F);
        chk("rd_en", rf_rd_en, 1);
        chk("rd_addr", rf_addr, 4'hF);
        idle();
        chk("rd_pulse", rf_rd_en, 0);

        // ALU frames
        send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
        chk("alu_en", alu_en, 1);
        chk("alu_a", op_a, 8'h12);
        chk("alu_b", op_b, 8'h34);
        chk("alu_fun", alu_fun, 1);
        send(8'hDD); send(8'h02);
        chk("alu2_en", alu_en, 1);
        chk("alu2_fun", alu_fun, 2);
        chk("alu2_a", op_a, 8'h12);
        chk("alu2_b", op_b, 8'h34);

        // error paths
        send(8'h55);
        chk("bad_opc_err", cmd_err, 1);
        chk("bad_opc_busy", busy, 0);
        send(8'hAA); send(8'h07); step(1'b0, 1'b1, 8'h99, 1'b1);
        chk("rxerr_err", cmd_err, 1);
        chk("rxerr_wr", rf_wr_en, 0);
        chk("rxerr_addr", rf_addr, 4'hF);
        chk("rxerr_busy", busy, 0);

        // reset mid-frame
        send(8'hCC); send(8'h11);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        send(8'hAA); send(8'h01); send(8'h02);
        chk("rstmid_op_a", op_a, 0);
        chk("rstmid_wr", rf_wr_en, 1);
        chk("rstmid_addr", rf_addr, 1);
        chk("rstmid_data", rf_wdata, 2);

        // back-to-back frames
        send(8'hAA); send(8'h01); send(8'h02);
        chk("b2b_wr", rf_wr_en, 1);
        send(8'hBB);
        chk("b2b_gap", rf_rd_en, 0);
        send(8'h03);
        chk("b2b_rd", rf_rd_en, 1);
        chk("b2b_addr", rf_addr, 3);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 40) begin
                case ($urandom_range(0, 4))
                    0: rb = 8'hAA;
                    1: rb = 8'hBB;
                    2: rb = 8'hCC;
                    3: rb = 8'hDD;
                    default: rb = 8'($urandom_range(0, 255));
                endcase
            end else begin
                rb = 8'($urandom_range(0, 255));
            end
            if (sel == 99)
                step(1'b1, 1'($urandom_range(0, 1)), rb, 1'b0);
            else if (sel < 75)
                step(1'b0, 1'b1, rb, $urandom_range(0, 29) == 0);
            else
                step(1'b0, 1'b0, rb, 1'($urandom_range(0, 1)));
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_cmd_decoder.md
# uart_rx_cmd_decoder

Frame decoder that sits directly downstream of the UART receiver. It consumes received bytes, together with their per-byte error flag, and assembles multi-byte command frames. Each complete frame is issued as a single-cycle command pulse toward the register file or the ALU. Malformed or corrupted frames are discarded and flagged.

## Interface
Parameters:
- ADDR_W, 4, register-file address width; address bytes are truncated to the low ADDR_W bits
- FUN_W, 4, ALU function width; function bytes are truncated to the low FUN_W bits

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- rx_data  in  8  received byte, valid only while rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte; back-to-back cycles legal
- rx_err  in  1  parity or stop error for this byte, sampled only with rx_valid
- rf_wr_en  out  1  one-cycle register-file write strobe
- rf_rd_en  out  1  one-cycle register-file read strobe
- rf_addr  out  ADDR_W  register-file address, held between commands
- rf_wdata  out  8  register-file write data, held
- alu_en  out  1  one-cycle ALU execute strobe
- alu_fun  out  FUN_W  ALU function, held
- op_a  out  8  ALU operand A, held
- op_b  out  8  ALU operand B, held
- busy  out  1  1 while a frame is partially received (state != IDLE)
- cmd_err  out  1  one-cycle strobe when a frame is rejected or aborted

## Operation
- Command opcodes (first byte of a frame):
  - 0xAA = RF write: opcode, ADDR, DATA
  - 0xBB = RF read: opcode, ADDR
  - 0xCC = ALU with operands: opcode, A, B, FUN
  - 0xDD = ALU without operands: opcode, FUN; reuses the held op_a/op_b
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN.
- The FSM advances only on rx_valid=1 with rx_err=0. Cycles without rx_valid hold the state; there is no timeout.
- Transitions from IDLE:
  - 0xAA -> WR_ADDR
  - 0xBB -> RD_ADDR
  - 0xCC -> ALU_A
  - 0xDD -> ALU_FUN
  - any other byte -> stay in IDLE and pulse cmd_err
- Remaining transitions:
  - WR_ADDR -> WR_DATA
  - ALU_A -> ALU_B -> ALU_FUN
  - WR_DATA, RD_ADDR and ALU_FUN -> IDLE, issuing the command
- Intermediate bytes (ADDR, A, B) go into shadow registers. Outputs are committed only on frame completion:
  - WR_DATA completion: rf_addr, rf_wdata, rf_wr_en=1
  - RD_ADDR completion: rf_addr, rf_rd_en=1
  - ALU_FUN completion after 0xCC: op_a, op_b, alu_fun, alu_en=1
  - ALU_FUN completion after 0xDD: alu_fun and alu_en=1 only; op_a/op_b unchanged
- rx_valid=1 with rx_err=1 in any state:
  - go to IDLE
  - pulse cmd_err
  - discard shadow contents
  - leave all held outputs unchanged
- Once in ALU_FUN, the FSM must remember whether it entered from 0xCC or 0xDD, so it knows whether to commit the operands.
- Opcode values inside a payload carry no special meaning; they are treated as data.

## Timing
- Reset values (on any rising edge with rst=1, regardless of state or rx_valid):
  - state = IDLE
  - all strobes = 0
  - rf_addr, rf_wdata, alu_fun, op_a, op_b = 0
  - busy = 0
  - shadows = 0
- Latency: a final byte with rx_valid at edge N gives its command strobe high for exactly the cycle after edge N, with the data outputs valid in the same cycle.
- busy rises in the cycle after the opcode is accepted and falls in the same cycle the command strobe rises.
- Throughput: a new opcode may arrive in the very cycle the previous command strobe is high. It is accepted, so there are no dead cycles between frames.
- At most one of rf_wr_en, rf_rd_en, alu_en and cmd_err is high in any cycle.
- Reset asserted mid-frame: the partial frame is dropped, no strobe is issued, and the next frame starts fresh.

## Test plan
- Write frame: bytes AA, 05, 3C on consecutive cycles -> one cycle later rf_wr_en=1, rf_addr=5, rf_wdata=0x3C; busy=0 the same cycle.
- Read frame with gaps: BB, idle 20 cycles, 0F -> rf_rd_en one-cycle pulse with rf_addr=0xF; busy=1 throughout the gap.
- ALU frames:
  - CC, 12, 34, 01 -> alu_en=1, op_a=0x12, op_b=0x34, alu_fun=1.
  - Then DD, 02 -> alu_en=1, alu_fun=2, op_a/op_b unchanged.
- Error paths:
  - Byte 55 in IDLE -> cmd_err pulse, state stays IDLE.
  - AA, 07, then 99 with rx_err=1 -> cmd_err pulse, no rf_wr_en, rf_addr keeps its previous value.
- Reset mid-frame: CC, 11, then rst for 1 cycle, then AA, 01, 02 -> op_a stays 0, and rf_wr_en fires with rf_addr=1, rf_wdata=2.
- Back-to-back: AA, 01, 02, BB, 03 with rx_valid high 5 consecutive cycles -> rf_wr_en, then rf_rd_en two cycles later, with no bytes lost.
